seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seg_pkg.sv | 23 ++
 rtl/hex_to_seg.sv | 12 +
 rtl/seven_seg_scanner.sv | 135 +++++++++++++
 tb/tb_seven_seg_scanner.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scanner: FSM states,
// the all-off segment pattern and the active-low hex glyph table.
`timescale 1ns/1ps
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRIVE = 2'd2,
        BLANK = 2'd3
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low, bit0 = segment a ... bit6 = segment g; index is the nibble value.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble-to-glyph decode; the scanner registers the result.
`timescale 1ns/1ps
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment display scanner with a per-frame input snapshot,
// inter-digit blanking and glitch-free registered anode/segment outputs.
`timescale 1ns/1ps
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    tick,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int               IDX_W      = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]       BLANK_LOAD = 8'(BLANK_CYCLES - 1);

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [7:0]              cnt, cnt_nxt;
    logic                    done_nxt;

    logic [4*NUM_DIGITS-1:0] snap_digits, snap_digits_nxt;
    logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_nxt;
    logic [NUM_DIGITS-1:0]   snap_blank, snap_blank_nxt;

    logic [3:0]              nibble;
    logic [6:0]              seg_dec;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [6:0]              seg_nxt;
    logic                    dp_nxt;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = LOAD;
                    idx_nxt   = '0;
                end
                LOAD:  state_nxt = DRIVE;
                DRIVE: begin
                    if (tick) begin
                        state_nxt = BLANK;
                        cnt_nxt   = BLANK_LOAD;
                    end
                end
                BLANK: begin
                    if (cnt == 8'd0) begin
                        if (idx == LAST_IDX) begin
                            state_nxt = LOAD;
                            idx_nxt   = '0;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = DRIVE;
                            idx_nxt   = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are computed from next-state values so anode and segments
    // for a digit land on the same edge that enters DRIVE.
    assign snap_digits_nxt = (state == LOAD) ? digits_in : snap_digits;
    assign snap_dp_nxt     = (state == LOAD) ? dp_in     : snap_dp;
    assign snap_blank_nxt  = (state == LOAD) ? blank_in  : snap_blank;
    assign nibble          = snap_digits_nxt[4*idx_nxt +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg_n  (seg_dec)
    );

    always_comb begin
        an_nxt  = '1;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        if (state_nxt == DRIVE) begin
            an_nxt = ~(NUM_DIGITS'(1) << idx_nxt);
            if (!snap_blank_nxt[idx_nxt]) begin
                seg_nxt = seg_dec;
                dp_nxt  = ~snap_dp_nxt[idx_nxt];
            end
        end
    end

    // frame_done is high during the LOAD cycle that follows the final blank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            an_n        <= '1;
            seg_n       <= SEG_OFF;
            dp_n        <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            cnt         <= cnt_nxt;
            snap_digits <= snap_digits_nxt;
            snap_dp     <= snap_dp_nxt;
            snap_blank  <= snap_blank_nxt;
            an_n        <= an_nxt;
            seg_n       <= seg_nxt;
            dp_n        <= dp_nxt;
            frame_done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner (4 digits, 2 blank cycles).
`timescale 1ns/1ps
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        reset, enable, tick;
    logic [15:0] digits_in;
    logic [3:0]  dp_in, blank_in;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int fd_count = 0;

    seven_seg_scanner #(.NUM_DIGITS(4), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .tick       (tick),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) fd_count++;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // From the first DRIVE cycle of a slot to the first cycle after its blanking.
    task automatic advance_slot();
        step(7);
        pulse_tick();
        step(2);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; tick = 1'b0;
        digits_in = 16'h0000; dp_in = 4'h0; blank_in = 4'h0;
        step(2);
        checks++; if (an_n !== 4'b1111) begin errors++; $display("FAIL reset_an actual=%b required=%b", an_n, 4'b1111); end
        checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset_seg actual=%b required=%b", seg_n, 7'h7F); end
        checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL reset_dp actual=%b required=1", dp_n); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done actual=%b required=0", frame_done); end
        enable = 1'b1; digits_in = 16'h1234; reset = 1'b0;
        step(1);
        checks++; if (an_n !== 4'b1111) begin errors++; $display("FAIL load_an actual=%b required=%b", an_n, 4'b1111); end
        step(1);
        checks++; if (an_n !== 4'b1110) begin errors++; $display("FAIL first_drive_an actual=%b required=%b", an_n, 4'b1110); end
    endtask

    task automatic test_basic_scan();
        logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] exp_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        for (int k = 0; k < 4; k++) begin
            checks++; if (an_n !== exp_an[k]) begin errors++; $display("FAIL scan_an[%0d] actual=%b required=%b", k, an_n, exp_an[k]); end
            checks++; if (seg_n !== exp_seg[k]) begin errors++; $display("FAIL scan_seg[%0d] actual=%b required=%b", k, seg_n, exp_seg[k]); end
            checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL scan_dp[%0d] actual=%b required=1", k, dp_n); end
            step(7);
            pulse_tick();
            checks++; if (an_n !== 4'b1111 || seg_n !== 7'h7F) begin errors++; $display("FAIL scan_blank1[%0d] actual=%b/%b required=1111/1111111", k, an_n, seg_n); end
            step(1);
            checks++; if (an_n !== 4'b1111) begin errors++; $display("FAIL scan_blank2[%0d] actual=%b required=1111", k, an_n); end
            step(1);
        end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL scan_frame_done actual=%b required=1", frame_done); end
        checks++; if (an_n !== 4'b1111) begin errors++; $display("FAIL scan_load_an actual=%b required=1111", an_n); end
        step(1);
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL scan_frame_done_clear actual=%b required=0", frame_done); end
        checks++; if (an_n !== 4'b1110 || seg_n !== 7'b0011001) begin errors++; $display("FAIL scan_wrap actual=%b/%b required=1110/0011001", an_n, seg_n); end
    endtask

    task automatic test_frame_coherency();
        advance_slot();
        advance_slot();
        checks++; if (an_n !== 4'b1011 || seg_n !== 7'b0100100) begin errors++; $display("FAIL coh_digit2 actual=%b/%b required=1011/0100100", an_n, seg_n); end
        step(2);
        digits_in = 16'hABCD;
        step(1);
        checks++; if (seg_n !== 7'b0100100) begin errors++; $display("FAIL coh_hold2 actual=%b required=0100100", seg_n); end
        step(4);
        pulse_tick();
        step(2);
        checks++; if (an_n !== 4'b0111 || seg_n !== 7'b1111001) begin errors++; $display("FAIL coh_digit3 actual=%b/%b required=0111/1111001", an_n, seg_n); end
        advance_slot();
        step(1);
        checks++; if (an_n !== 4'b1110 || seg_n !== 7'b0100001) begin errors++; $display("FAIL coh_next_d actual=%b/%b required=1110/0100001", an_n, seg_n); end
    endtask

    task automatic test_blank_dp();
        blank_in = 4'b0010; dp_in = 4'b0001;
        step(1);
        checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL bdp_not_yet actual=%b required=1", dp_n); end
        step(6);
        pulse_tick();
        step(2);
        for (int k = 0; k < 3; k++) advance_slot();
        step(1);
        checks++; if (an_n !== 4'b1110 || seg_n !== 7'b0100001 || dp_n !== 1'b0) begin errors++; $display("FAIL bdp_digit0 actual=%b/%b/%b required=1110/0100001/0", an_n, seg_n, dp_n); end
        advance_slot();
        checks++; if (an_n !== 4'b1101 || seg_n !== 7'h7F || dp_n !== 1'b1) begin errors++; $display("FAIL bdp_digit1 actual=%b/%b/%b required=1101/1111111/1", an_n, seg_n, dp_n); end
        blank_in = 4'b0000; dp_in = 4'b0000;
        for (int k = 0; k < 3; k++) advance_slot();
        step(1);
        checks++; if (dp_n !== 1'b1 || seg_n !== 7'b0100001) begin errors++; $display("FAIL bdp_cleared actual=%b/%b required=0100001/1", seg_n, dp_n); end
    endtask

    task automatic test_ignored_ticks();
        int start_fd;
        start_fd = fd_count;
        step(7);
        pulse_tick();
        pulse_tick();
        checks++; if (an_n !== 4'b1111) begin errors++; $display("FAIL ign_blank_tick actual=%b required=1111", an_n); end
        step(1);
        checks++; if (an_n !== 4'b1101) begin errors++; $display("FAIL ign_after_blank actual=%b required=1101", an_n); end
        step(3);
        checks++; if (an_n !== 4'b1101) begin errors++; $display("FAIL ign_not_queued actual=%b required=1101", an_n); end
        tick = 1'b1;
        step(2);
        tick = 1'b0;
        checks++; if (an_n !== 4'b1111) begin errors++; $display("FAIL ign_b2b_blank actual=%b required=1111", an_n); end
        step(1);
        checks++; if (an_n !== 4'b1011 || seg_n !== 7'b0000011) begin errors++; $display("FAIL ign_b2b_advance actual=%b/%b required=1011/0000011", an_n, seg_n); end
        advance_slot();
        checks++; if (an_n !== 4'b0111) begin errors++; $display("FAIL ign_digit3 actual=%b required=0111", an_n); end
        advance_slot();
        pulse_tick();
        step(2);
        checks++; if (an_n !== 4'b1110) begin errors++; $display("FAIL ign_load_tick actual=%b required=1110", an_n); end
        checks++; if (fd_count - start_fd !== 1) begin errors++; $display("FAIL ign_frame_done_count actual=%0d required=1", fd_count - start_fd); end
    endtask

    task automatic test_enable_drop();
        advance_slot();
        advance_slot();
        step(3);
        checks++; if (an_n !== 4'b1011) begin errors++; $display("FAIL en_digit2 actual=%b required=1011", an_n); end
        enable = 1'b0;
        step(1);
        checks++; if (an_n !== 4'b1111 || seg_n !== 7'h7F || dp_n !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("FAIL en_drop actual=%b/%b/%b/%b required=1111/1111111/1/0", an_n, seg_n, dp_n, frame_done); end
        step(2);
        checks++; if (an_n !== 4'b1111) begin errors++; $display("FAIL en_idle_hold actual=%b required=1111", an_n); end
        enable = 1'b1;
        step(1);
        checks++; if (an_n !== 4'b1111) begin errors++; $display("FAIL en_load actual=%b required=1111", an_n); end
        step(1);
        checks++; if (an_n !== 4'b1110 || seg_n !== 7'b0100001) begin errors++; $display("FAIL en_restart actual=%b/%b required=1110/0100001", an_n, seg_n); end
    endtask

    task automatic test_async_reset();
        advance_slot();
        checks++; if (an_n !== 4'b1101) begin errors++; $display("FAIL ar_digit1 actual=%b required=1101", an_n); end
        #2 reset = 1'b1;
        #1;
        checks++; if (an_n !== 4'b1111 || seg_n !== 7'h7F || dp_n !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("FAIL ar_immediate actual=%b/%b/%b/%b required=1111/1111111/1/0", an_n, seg_n, dp_n, frame_done); end
        step(2);
        checks++; if (an_n !== 4'b1111) begin errors++; $display("FAIL ar_held actual=%b required=1111", an_n); end
        reset = 1'b0;
        step(1);
        checks++; if (an_n !== 4'b1111) begin errors++; $display("FAIL ar_load actual=%b required=1111", an_n); end
        step(1);
        checks++; if (an_n !== 4'b1110 || seg_n !== 7'b0100001) begin errors++; $display("FAIL ar_restart actual=%b/%b required=1110/0100001", an_n, seg_n); end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_frame_coherency();
        test_blank_dp();
        test_ignored_ticks();
        test_enable_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
